// File: rtl/amba_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : amba_axi4_lite_master
// Description : Single-outstanding AXI4-Lite initiator. One command in,
//               one AW/W/B or AR/R transaction out, one response back.
// Revision    : 1.0 - initial release
// ============================================================================
module amba_axi4_lite_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                ACLK,
    input  logic                ARSTn,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_write,
    input  logic [ADDR_W-1:0]   i_cmd_addr,
    input  logic [DATA_W-1:0]   i_cmd_wdata,
    input  logic [DATA_W/8-1:0] i_cmd_wstrb,
    input  logic [2:0]          i_cmd_prot,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic                o_rsp_write,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic [1:0]          o_rsp_resp,
    output logic                o_busy,
    output logic                o_timeout,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [ADDR_W-1:0]   o_awaddr,
    output logic [2:0]          o_awprot,
    output logic                o_wvalid,
    input  logic                i_wready,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb,
    input  logic                i_bvalid,
    output logic                o_bready,
    input  logic [1:0]          i_bresp,
    output logic                o_arvalid,
    input  logic                i_arready,
    output logic [ADDR_W-1:0]   o_araddr,
    output logic [2:0]          o_arprot,
    input  logic                i_rvalid,
    output logic                o_rready,
    input  logic [DATA_W-1:0]   i_rdata,
    input  logic [1:0]          i_rresp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR_AW = 3'd1;
    localparam logic [2:0] S_WR_W  = 3'd2;
    localparam logic [2:0] S_WR_B  = 3'd3;
    localparam logic [2:0] S_RD_AR = 3'd4;
    localparam logic [2:0] S_RD_R  = 3'd5;
    localparam logic [2:0] S_RSP   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic              run_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [2:0]        prot_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              timeout_q, timeout_d;

    logic cmd_acc, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, in_wait;

    assign cmd_acc = o_cmd_ready & i_cmd_valid;
    assign aw_hs   = (state_q == S_WR_AW) & i_awready;
    assign w_hs    = (state_q == S_WR_W)  & i_wready;
    assign b_hs    = (state_q == S_WR_B)  & i_bvalid;
    assign ar_hs   = (state_q == S_RD_AR) & i_arready;
    assign r_hs    = (state_q == S_RD_R)  & i_rvalid;
    assign any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    assign in_wait = (state_q != S_IDLE) && (state_q != S_RSP);
    assign cnt_inc = cnt_q + CNT_W'(1);

    // run_q keeps o_cmd_ready low while reset is asserted and for the first edge after
    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_acc) state_d = i_cmd_write ? S_WR_AW : S_RD_AR;
            S_WR_AW: if (aw_hs)   state_d = S_WR_W;
            S_WR_W:  if (w_hs)    state_d = S_WR_B;
            S_WR_B:  if (b_hs)    state_d = S_RSP;
            S_RD_AR: if (ar_hs)   state_d = S_RD_R;
            S_RD_R:  if (r_hs)    state_d = S_RSP;
            S_RSP:   if (i_rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready = (state_q == S_IDLE) & run_q;
        o_awvalid   = (state_q == S_WR_AW);
        o_wvalid    = (state_q == S_WR_W);
        o_bready    = (state_q == S_WR_B);
        o_arvalid   = (state_q == S_RD_AR);
        o_rready    = (state_q == S_RD_R);
        o_rsp_valid = (state_q == S_RSP);
        o_busy      = (state_q != S_IDLE);
    end

    assign o_awaddr    = addr_q;
    assign o_awprot    = prot_q;
    assign o_araddr    = addr_q;
    assign o_arprot    = prot_q;
    assign o_wdata     = wdata_q;
    assign o_wstrb     = wstrb_q;
    assign o_rsp_write = write_q;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_resp  = resp_q;
    assign o_timeout   = timeout_q;

    // Stall counter saturates at CNT_MAX; with TIMEOUT_CYCLES=0 CNT_MAX is 0 so it never moves
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (cmd_acc) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else if (any_hs) begin
            cnt_d = '0;
        end else if (in_wait && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            prot_q    <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            if (cmd_acc) begin
                write_q <= i_cmd_write;
                addr_q  <= i_cmd_addr;
                wdata_q <= i_cmd_wdata;
                wstrb_q <= i_cmd_wstrb;
                prot_q  <= i_cmd_prot;
            end
            if (b_hs) begin
                rdata_q <= '0;
                resp_q  <= i_bresp;
            end
            if (r_hs) begin
                rdata_q <= i_rdata;
                resp_q  <= i_rresp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_amba_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_amba_axi4_lite_master
// Description : Self-checking bench: behavioural AXI slave, command-level
//               reference memory and a channel protocol monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amba_axi4_lite_master;

    localparam int TO = 8;

    logic        ACLK = 1'b0;
    logic        ARSTn = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_write = 1'b0;
    logic [31:0] i_cmd_addr = '0;
    logic [31:0] i_cmd_wdata = '0;
    logic [3:0]  i_cmd_wstrb = '0;
    logic [2:0]  i_cmd_prot = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic        o_rsp_write;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic        o_busy, o_timeout;
    logic        o_awvalid, i_awready = 1'b0;
    logic [31:0] o_awaddr;
    logic [2:0]  o_awprot;
    logic        o_wvalid, i_wready = 1'b0;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        i_bvalid = 1'b0, o_bready;
    logic [1:0]  i_bresp = '0;
    logic        o_arvalid, i_arready = 1'b0;
    logic [31:0] o_araddr;
    logic [2:0]  o_arprot;
    logic        i_rvalid = 1'b0, o_rready;
    logic [31:0] i_rdata = '0;
    logic [1:0]  i_rresp = '0;

    always #5 ACLK = ~ACLK;

    amba_axi4_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARSTn(ARSTn),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .i_cmd_prot(i_cmd_prot), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_write(o_rsp_write), .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
        .o_busy(o_busy), .o_timeout(o_timeout),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awprot(o_awprot),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arprot(o_arprot),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // slave behaviour knobs
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] resp_cfg = 2'b00;

    logic [31:0] slv_mem [16] = '{default: 32'h0};
    logic [31:0] ref_mem [16] = '{default: 32'h0};

    // ---------------- protocol monitor / slave storage ----------------
    logic [31:0] cap_awaddr = '0, cap_araddr = '0;
    logic [2:0]  cap_awprot = '0, cap_arprot = '0;
    logic        aw_done = 1'b0;
    int          mon_err = 0, awv_cnt = 0, wv_cnt = 0;
    logic        p_aw_st = 0, p_w_st = 0, p_ar_st = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    logic [3:0]  p_wstrb = '0;

    always @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            aw_done <= 1'b0;
            p_aw_st <= 1'b0;
            p_w_st  <= 1'b0;
            p_ar_st <= 1'b0;
        end else begin
            if (p_aw_st && (!o_awvalid || o_awaddr !== p_awaddr)) mon_err <= mon_err + 1;
            if (p_w_st && (!o_wvalid || o_wdata !== p_wdata || o_wstrb !== p_wstrb)) mon_err <= mon_err + 1;
            if (p_ar_st && (!o_arvalid || o_araddr !== p_araddr)) mon_err <= mon_err + 1;
            if (o_wvalid && !aw_done) mon_err <= mon_err + 1;
            p_aw_st  <= o_awvalid && !i_awready;
            p_w_st   <= o_wvalid && !i_wready;
            p_ar_st  <= o_arvalid && !i_arready;
            p_awaddr <= o_awaddr;
            p_wdata  <= o_wdata;
            p_wstrb  <= o_wstrb;
            p_araddr <= o_araddr;
            if (o_awvalid) awv_cnt <= awv_cnt + 1;
            if (o_wvalid)  wv_cnt  <= wv_cnt + 1;
            if (o_awvalid && i_awready) begin
                cap_awaddr <= o_awaddr;
                cap_awprot <= o_awprot;
                aw_done    <= 1'b1;
            end
            if (o_wvalid && i_wready) begin
                aw_done <= 1'b0;
                for (int b = 0; b < 4; b++)
                    if (o_wstrb[b]) slv_mem[cap_awaddr[3:0]][8*b +: 8] <= o_wdata[8*b +: 8];
            end
            if (o_arvalid && i_arready) begin
                cap_araddr <= o_araddr;
                cap_arprot <= o_arprot;
            end
        end
    end

    // ---------------- slave channel drivers (negedge) ----------------
    initial begin : aw_slv
        int st;
        st = 0;
        forever begin
            @(negedge ACLK);
            if (!ARSTn || i_awready) begin i_awready = 1'b0; st = 0; end
            else if (o_awvalid) begin if (st >= aw_dly) i_awready = 1'b1; else st++; end
        end
    end

    initial begin : w_slv
        int st;
        st = 0;
        forever begin
            @(negedge ACLK);
            if (!ARSTn || i_wready) begin i_wready = 1'b0; st = 0; end
            else if (o_wvalid) begin if (st >= w_dly) i_wready = 1'b1; else st++; end
        end
    end

    initial begin : b_slv
        int st;
        st = 0;
        forever begin
            @(negedge ACLK);
            if (!ARSTn || i_bvalid) begin i_bvalid = 1'b0; st = 0; end
            else if (o_bready) begin
                if (st >= b_dly) begin i_bvalid = 1'b1; i_bresp = resp_cfg; end
                else st++;
            end
        end
    end

    initial begin : ar_slv
        int st;
        st = 0;
        forever begin
            @(negedge ACLK);
            if (!ARSTn || i_arready) begin i_arready = 1'b0; st = 0; end
            else if (o_arvalid) begin if (st >= ar_dly) i_arready = 1'b1; else st++; end
        end
    end

    initial begin : r_slv
        int st;
        st = 0;
        forever begin
            @(negedge ACLK);
            if (!ARSTn || i_rvalid) begin i_rvalid = 1'b0; st = 0; end
            else if (o_rready) begin
                if (st >= r_dly) begin
                    i_rvalid = 1'b1;
                    i_rdata  = slv_mem[cap_araddr[3:0]];
                    i_rresp  = resp_cfg;
                end else st++;
            end
        end
    end

    // ---------------- one full command, checked against the reference ----------------
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot, input int hold,
                          input string nm);
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int cyc;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[addr[3:0]][8*b +: 8] = data[8*b +: 8];
            exp_rdata = 32'h0;
        end else begin
            exp_rdata = ref_mem[addr[3:0]];
        end
        exp_resp = resp_cfg;

        @(negedge ACLK);
        i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = addr;
        i_cmd_wdata = data; i_cmd_wstrb = strb; i_cmd_prot = prot;
        cyc = 0;
        while (!o_cmd_ready && cyc < 200) begin @(negedge ACLK); cyc++; end
        n_tests++;
        if (o_cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s cmd_ready: got %b required 1", nm, o_cmd_ready);
            i_cmd_valid = 1'b0; return;
        end
        @(posedge ACLK); #1;
        i_cmd_valid = 1'b0;
        n_tests++;
        if ((wr ? o_awvalid : o_arvalid) !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL %s addr-valid latency: got %b busy %b required 1", nm,
                               wr ? o_awvalid : o_arvalid, o_busy);
        end

        cyc = 0;
        while (!o_rsp_valid && cyc < 200) begin @(negedge ACLK); cyc++; end
        n_tests++;
        if (o_rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s rsp_valid: got %b required 1", nm, o_rsp_valid); return;
        end

        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            i_cmd_valid = 1'b1; i_cmd_write = ~wr; i_cmd_addr = addr ^ 32'h5;
            n_tests++;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== exp_rdata || o_cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s rsp hold: valid %b rdata %h cmd_ready %b required 1 %h 0",
                         nm, o_rsp_valid, o_rsp_rdata, o_cmd_ready, exp_rdata);
            end
        end
        @(negedge ACLK);
        i_cmd_valid = 1'b0;

        n_tests++;
        if (o_rsp_write !== wr || o_rsp_rdata !== exp_rdata || o_rsp_resp !== exp_resp) begin
            n_fail++;
            $display("FAIL %s rsp: write %b rdata %h resp %b required %b %h %b", nm,
                     o_rsp_write, o_rsp_rdata, o_rsp_resp, wr, exp_rdata, exp_resp);
        end
        n_tests++;
        if ((wr ? cap_awaddr : cap_araddr) !== addr || (wr ? cap_awprot : cap_arprot) !== prot) begin
            n_fail++;
            $display("FAIL %s bus addr/prot: got %h/%0d required %h/%0d", nm,
                     wr ? cap_awaddr : cap_araddr, wr ? cap_awprot : cap_arprot, addr, prot);
        end
        if (wr) begin
            n_tests++;
            if (slv_mem[addr[3:0]] !== ref_mem[addr[3:0]]) begin
                n_fail++;
                $display("FAIL %s slave word: got %h required %h", nm,
                         slv_mem[addr[3:0]], ref_mem[addr[3:0]]);
            end
        end

        i_rsp_ready = 1'b1;
        @(posedge ACLK); #1;
        i_rsp_ready = 1'b0;
        n_tests++;
        if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s return to idle: rsp_valid %b cmd_ready %b busy %b required 0 1 0",
                     nm, o_rsp_valid, o_cmd_ready, o_busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge ACLK);
        n_tests++;
        if ({o_cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid,
             o_busy, o_timeout} !== 9'b0 || o_rsp_rdata !== 32'h0 || o_rsp_resp !== 2'b00 ||
            o_awaddr !== 32'h0 || o_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset outputs: some output nonzero during reset");
        end
        ARSTn = 1'b1;
        @(negedge ACLK);
        n_tests++;
        if (o_cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset release cmd_ready: got %b required 1", o_cmd_ready);
        end
    endtask

    task automatic test_basic_write();
        do_cmd(1'b1, 32'h0, 32'h0000_aaaa, 4'hF, 3'd0, 0, "basic_write");
    endtask

    task automatic test_program_read();
        do_cmd(1'b1, 32'h1, 32'hbbbb_0000, 4'hF, 3'd1, 0, "prog_r1");
        do_cmd(1'b1, 32'h3, 32'h0000_0003, 4'hF, 3'd2, 0, "prog_ctrl");
        do_cmd(1'b1, 32'h0, 32'h1234_5678, 4'b0010, 3'd3, 0, "partial_strb");
        do_cmd(1'b1, 32'h2, 32'hdead_beef, 4'b0000, 3'd0, 0, "zero_strb");
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 3'd4, 0, "read_r0");
        do_cmd(1'b0, 32'h1, 32'h0, 4'h0, 3'd5, 0, "read_r1");
        do_cmd(1'b0, 32'h2, 32'h0, 4'h0, 3'd6, 0, "read_r2");
        do_cmd(1'b0, 32'h3, 32'h0, 4'h0, 3'd7, 0, "read_ctrl");
    endtask

    task automatic test_stall();
        int a0, w0;
        aw_dly = 5; w_dly = 3;
        a0 = awv_cnt; w0 = wv_cnt;
        do_cmd(1'b1, 32'h5, 32'hcafe_f00d, 4'hF, 3'd2, 0, "stall_write");
        n_tests++;
        if (awv_cnt - a0 != 6 || wv_cnt - w0 != 4) begin
            n_fail++; $display("FAIL stall valid cycles: aw %0d w %0d required 6 4",
                               awv_cnt - a0, wv_cnt - w0);
        end
        aw_dly = 0; w_dly = 0;
    endtask

    task automatic test_rsp_hold();
        r_dly = 2;
        do_cmd(1'b0, 32'h1, 32'h0, 4'h0, 3'd0, 4, "rsp_hold");
        r_dly = 0;
        do_cmd(1'b1, 32'h6, 32'h6666_0606, 4'hF, 3'd0, 0, "after_hold");
    endtask

    task automatic test_error_resp();
        resp_cfg = 2'b10;
        do_cmd(1'b1, 32'h7, 32'h0707_0707, 4'hF, 3'd0, 0, "slverr_write");
        resp_cfg = 2'b11;
        do_cmd(1'b0, 32'h7, 32'h0, 4'h0, 3'd0, 0, "decerr_read");
        resp_cfg = 2'b00;
        do_cmd(1'b0, 32'h6, 32'h0, 4'h0, 3'd0, 0, "okay_after_err");
        n_tests++;
        if (o_timeout !== 1'b0) begin
            n_fail++; $display("FAIL err no timeout: got %b required 0", o_timeout);
        end
    endtask

    task automatic test_timeout_sticky();
        b_dly = TO + 1;
        do_cmd(1'b1, 32'h8, 32'h8888_8888, 4'hF, 3'd0, 0, "slow_b");
        n_tests++;
        if (o_timeout !== 1'b1) begin
            n_fail++; $display("FAIL sticky timeout: got %b required 1", o_timeout);
        end
        b_dly = TO - 1;
        do_cmd(1'b0, 32'h8, 32'h0, 4'h0, 3'd0, 0, "after_timeout");
        n_tests++;
        if (o_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout cleared by accept: got %b required 0", o_timeout);
        end
        b_dly = 0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            aw_dly = $urandom_range(0, 5); w_dly = $urandom_range(0, 5);
            b_dly  = $urandom_range(0, 5); ar_dly = $urandom_range(0, 5);
            r_dly  = $urandom_range(0, 5); resp_cfg = 2'($urandom_range(0, 3));
            do_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
                   4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), "random");
            n_tests++;
            if (o_timeout !== 1'b0) begin
                n_fail++; $display("FAIL random timeout: got %b required 0", o_timeout);
            end
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; resp_cfg = 2'b00;
    endtask

    task automatic test_timeout_reset();
        ar_dly = 100000;
        @(negedge ACLK);
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 32'h9; i_cmd_prot = 3'd1;
        @(posedge ACLK); #1;
        i_cmd_valid = 1'b0;
        repeat (TO - 1) @(posedge ACLK);
        #1;
        n_tests++;
        if (o_timeout !== 1'b0 || o_arvalid !== 1'b1) begin
            n_fail++; $display("FAIL timeout early: timeout %b arvalid %b required 0 1",
                               o_timeout, o_arvalid);
        end
        @(posedge ACLK); #1;
        n_tests++;
        if (o_timeout !== 1'b1 || o_arvalid !== 1'b1) begin
            n_fail++; $display("FAIL timeout at limit: timeout %b arvalid %b required 1 1",
                               o_timeout, o_arvalid);
        end
        #2 ARSTn = 1'b0;
        #1;
        n_tests++;
        if ({o_cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid,
             o_busy, o_timeout} !== 9'b0 || o_araddr !== 32'h0 || o_arprot !== 3'd0) begin
            n_fail++; $display("FAIL async reset mid-transaction: outputs not all zero");
        end
        ar_dly = 0;
        @(negedge ACLK);
        @(negedge ACLK);
        ARSTn = 1'b1;
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_program_read();
        test_stall();
        test_rsp_hold();
        test_error_resp();
        test_timeout_sticky();
        test_random();
        test_timeout_reset();
        n_tests++;
        if (mon_err != 0) begin
            n_fail++; $display("FAIL protocol monitor: %0d violations required 0", mon_err);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
